// File: rtl/fpu_seq.sv
// Sequential IEEE-754 add/sub/mul unit; latency 6 (add/sub), 5 (mul), 2 (special).
// One op in flight; result held while out_ready=0. FPU_ROUND_NEAREST_EN selects RNE, else truncation.
module fpu_seq #(
  parameter int BITNESS = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [BITNESS-1:0] first,
  input  logic [BITNESS-1:0] second,
  input  logic [1:0]         command,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [BITNESS-1:0] result,
  output logic [3:0]         flags
);
  localparam int EXP_W = (BITNESS == 16) ? 5 : (BITNESS == 64) ? 11 : 8;
  localparam int MAN_W = (BITNESS == 16) ? 10 : (BITNESS == 64) ? 52 : 23;
  localparam int WM    = MAN_W + 5;
  localparam int EW    = EXP_W + 2;
  localparam logic signed [EW-1:0] E_BIAS = EW'((1 << (EXP_W - 1)) - 1);
  localparam logic signed [EW-1:0] E_MAX  = EW'((1 << EXP_W) - 1);
  localparam logic [BITNESS-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  localparam logic [3:0] S_IDLE = 4'd0, S_UNPACK = 4'd1, S_ALIGN = 4'd2, S_SUM = 4'd3,
                         S_MUL = 4'd4, S_NORM = 4'd5, S_ROUND = 4'd6, S_PACK = 4'd7,
                         S_DONE = 4'd8;

  logic [3:0]              r_state;
  logic [BITNESS-1:0]      r_a, r_b;
  logic [1:0]              r_cmd;
  logic                    r_sa, r_sb, r_s, r_sub;
  logic [EXP_W-1:0]        r_ea, r_eb;
  logic [MAN_W:0]          r_ma, r_mb;
  logic [MAN_W+3:0]        r_x, r_y;
  logic [WM-1:0]           r_m;
  logic signed [EW-1:0]    r_e;
  logic                    r_zero, r_uf, r_special, r_inexact;
  logic [BITNESS-1:0]      r_spec_res;
  logic [3:0]              r_spec_flg;
  logic [MAN_W-1:0]        r_mant;
  logic [BITNESS-1:0]      r_result;
  logic [3:0]              r_flags;

  // Unpack / special-case classification
  logic [EXP_W-1:0] w_ea, w_eb;
  logic [MAN_W-1:0] w_fa, w_fb;
  logic w_sa, w_sb, w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_a_zero, w_b_zero;
  logic w_spec;
  logic [BITNESS-1:0] w_spec_res;
  logic [3:0] w_spec_flg;

  assign w_ea     = r_a[BITNESS-2 -: EXP_W];
  assign w_eb     = r_b[BITNESS-2 -: EXP_W];
  assign w_fa     = r_a[MAN_W-1:0];
  assign w_fb     = r_b[MAN_W-1:0];
  assign w_sa     = r_a[BITNESS-1];
  assign w_sb     = r_b[BITNESS-1] ^ (r_cmd == 2'b01);
  assign w_a_nan  = (&w_ea) && (|w_fa);
  assign w_b_nan  = (&w_eb) && (|w_fb);
  assign w_a_inf  = (&w_ea) && !(|w_fa);
  assign w_b_inf  = (&w_eb) && !(|w_fb);
  assign w_a_zero = (w_ea == '0);
  assign w_b_zero = (w_eb == '0);

  always_comb begin
    w_spec     = 1'b1;
    w_spec_res = QNAN;
    w_spec_flg = 4'b0000;
    if (r_cmd == 2'b11) begin
      w_spec_flg = 4'b1000;
    end else if (w_a_nan || w_b_nan) begin
      w_spec_flg = 4'b0000;
    end else if (r_cmd == 2'b10) begin
      if ((w_a_inf && w_b_zero) || (w_a_zero && w_b_inf))
        w_spec_flg = 4'b1000;
      else if (w_a_inf || w_b_inf)
        w_spec_res = {w_sa ^ w_sb, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      else if (w_a_zero || w_b_zero)
        w_spec_res = {w_sa ^ w_sb, {(BITNESS-1){1'b0}}};
      else
        w_spec = 1'b0;
    end else begin
      if (w_a_inf && w_b_inf && (w_sa != w_sb))
        w_spec_flg = 4'b1000;
      else if (w_a_inf)
        w_spec_res = {w_sa, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      else if (w_b_inf)
        w_spec_res = {w_sb, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      else
        w_spec = 1'b0;
    end
  end

  // Alignment: swap so the larger magnitude is first, shift the other with sticky collapse
  logic             w_a_big;
  logic [EXP_W-1:0] w_big_e, w_sml_e, w_diff, w_sh;
  logic [MAN_W:0]   w_big_m, w_sml_m;
  logic [MAN_W+3:0] w_sml_ext, w_shifted;
  logic             w_lost;

  assign w_a_big   = {r_ea, r_ma} >= {r_eb, r_mb};
  assign w_big_e   = w_a_big ? r_ea : r_eb;
  assign w_sml_e   = w_a_big ? r_eb : r_ea;
  assign w_big_m   = w_a_big ? r_ma : r_mb;
  assign w_sml_m   = w_a_big ? r_mb : r_ma;
  assign w_diff    = w_big_e - w_sml_e;
  assign w_sh      = (w_diff > EXP_W'(MAN_W + 4)) ? EXP_W'(MAN_W + 4) : w_diff;
  assign w_sml_ext = {w_sml_m, 3'b000};
  assign w_shifted = w_sml_ext >> w_sh;
  assign w_lost    = |(w_sml_ext & ~({(MAN_W+4){1'b1}} << w_sh));

  logic [2*MAN_W+1:0] w_prod;
  assign w_prod = r_ma * r_mb;

  function automatic logic [EW-1:0] f_lzc(input logic [WM-2:0] v);
    f_lzc = EW'(WM - 1);
    for (int i = 0; i < WM - 1; i++)
      if (v[i]) f_lzc = EW'(WM - 2 - i);
  endfunction

  logic [EW-1:0]        w_lzc;
  logic signed [EW-1:0] w_e_norm;
  logic [WM-1:0]        w_m_norm;

  assign w_lzc = f_lzc(r_m[WM-2:0]);
  always_comb begin
    if (r_m[WM-1]) begin
      w_m_norm = {1'b0, r_m[WM-1:2], r_m[1] | r_m[0]};
      w_e_norm = r_e + EW'(1);
    end else begin
      w_m_norm = r_m << w_lzc;
      w_e_norm = r_e - $signed(w_lzc);
    end
  end

  logic             w_up;
  logic [MAN_W+1:0] w_rnd;
`ifdef FPU_ROUND_NEAREST_EN
  assign w_up = r_m[2] && (r_m[1] || r_m[0] || r_m[3]);
`else
  assign w_up = 1'b0;
`endif
  assign w_rnd = {1'b0, r_m[MAN_W+3:3]} + (MAN_W+2)'(w_up);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_a <= '0; r_b <= '0; r_cmd <= '0;
      r_sa <= 1'b0; r_sb <= 1'b0; r_s <= 1'b0; r_sub <= 1'b0;
      r_ea <= '0; r_eb <= '0; r_ma <= '0; r_mb <= '0;
      r_x <= '0; r_y <= '0; r_m <= '0; r_e <= '0;
      r_zero <= 1'b0; r_uf <= 1'b0; r_special <= 1'b0; r_inexact <= 1'b0;
      r_spec_res <= '0; r_spec_flg <= '0; r_mant <= '0;
      r_result <= '0; r_flags <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (in_valid) begin
          r_a <= first; r_b <= second; r_cmd <= command;
          r_state <= S_UNPACK;
        end
        S_UNPACK: begin
          r_sa <= w_sa; r_sb <= w_sb;
          r_ea <= w_ea; r_eb <= w_eb;
          r_ma <= w_a_zero ? '0 : {1'b1, w_fa};
          r_mb <= w_b_zero ? '0 : {1'b1, w_fb};
          r_special <= w_spec; r_spec_res <= w_spec_res; r_spec_flg <= w_spec_flg;
          r_zero <= 1'b0; r_uf <= 1'b0;
          r_state <= w_spec ? S_PACK : (r_cmd == 2'b10) ? S_MUL : S_ALIGN;
        end
        S_ALIGN: begin
          r_x <= {w_big_m, 3'b000};
          r_y <= {w_shifted[MAN_W+3:1], w_shifted[0] | w_lost};
          r_e <= $signed({2'b00, w_big_e});
          r_s <= w_a_big ? r_sa : r_sb;
          r_sub <= r_sa ^ r_sb;
          r_state <= S_SUM;
        end
        S_SUM: begin
          r_m <= r_sub ? ({1'b0, r_x} - {1'b0, r_y}) : ({1'b0, r_x} + {1'b0, r_y});
          r_state <= S_NORM;
        end
        S_MUL: begin
          r_m <= {w_prod[2*MAN_W+1:MAN_W-2], |w_prod[MAN_W-3:0]};
          r_e <= $signed({2'b00, r_ea}) + $signed({2'b00, r_eb}) - E_BIAS;
          r_s <= r_sa ^ r_sb;
          r_state <= S_NORM;
        end
        S_NORM: begin
          if (r_m == '0) begin
            r_zero <= 1'b1; r_s <= 1'b0;
          end else if (w_e_norm <= 0) begin
            r_zero <= 1'b1; r_uf <= 1'b1; r_m <= '0;
          end else begin
            r_m <= w_m_norm; r_e <= w_e_norm;
          end
          r_state <= S_ROUND;
        end
        S_ROUND: begin
          r_inexact <= |r_m[2:0];
          if (w_rnd[MAN_W+1]) begin
            r_mant <= '0; r_e <= r_e + EW'(1);
          end else begin
            r_mant <= w_rnd[MAN_W-1:0];
          end
          r_state <= S_PACK;
        end
        S_PACK: begin
          if (r_special) begin
            r_result <= r_spec_res; r_flags <= r_spec_flg;
          end else if (r_zero) begin
            r_result <= {r_s, {(BITNESS-1){1'b0}}}; r_flags <= {2'b00, r_uf, 1'b0};
          end else if (r_e >= E_MAX) begin
            r_result <= {r_s, {EXP_W{1'b1}}, {MAN_W{1'b0}}}; r_flags <= 4'b0101;
          end else begin
            r_result <= {r_s, r_e[EXP_W-1:0], r_mant}; r_flags <= {3'b000, r_inexact};
          end
          r_state <= S_DONE;
        end
        S_DONE: if (out_ready) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE) && !reset;
  assign out_valid = (r_state == S_DONE);
  assign result    = r_result;
  assign flags     = r_flags;
endmodule
